// File: rtl/fir_filter_ctrl.sv
// FIR filter sequencer: sample buffer writes, per-tap address
// generation, pipeline freeze/flush and post-reset buffer clearing.
module fir_filter_ctrl #(
  parameter int NUM_TAPS   = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  stall_i,
  input  logic                  abort_i,
  output logic                  sample_we_o,
  output logic                  sample_wzero_o,
  output logic [ADDR_WIDTH-1:0] sample_waddr_o,
  output logic [ADDR_WIDTH-1:0] sample_raddr_o,
  output logic [ADDR_WIDTH-1:0] coef_raddr_o,
  output logic                  issue_o,
  output logic                  overwrite_o,
  output logic                  output_valid_o,
  output logic                  freeze_o,
  output logic                  flush_o,
  output logic                  busy_o
);

  if (NUM_TAPS < 2) begin : g_taps_chk
    $error("fir_filter_ctrl: NUM_TAPS must be >= 2");
  end
  if ((2 ** ADDR_WIDTH) != NUM_TAPS) begin : g_addr_chk
    $error("fir_filter_ctrl: 2**ADDR_WIDTH must equal NUM_TAPS");
  end

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_TAPS - 1);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    MAC   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] newest_q, newest_d;
  logic [ADDR_WIDTH-1:0] tap_q, tap_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      wptr_q    <= '0;
      newest_q  <= '0;
      tap_q     <= '0;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      newest_q  <= newest_d;
      tap_q     <= tap_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wptr_d         = wptr_q;
    newest_d       = newest_q;
    tap_d          = tap_q;
    clr_cnt_d      = clr_cnt_q;
    in_ready_o     = 1'b0;
    sample_we_o    = 1'b0;
    sample_wzero_o = 1'b0;
    sample_waddr_o = '0;
    sample_raddr_o = '0;
    coef_raddr_o   = '0;
    issue_o        = 1'b0;
    overwrite_o    = 1'b0;
    output_valid_o = 1'b0;
    freeze_o       = stall_i;
    flush_o        = abort_i;
    busy_o         = (state_q != IDLE);

    unique case (state_q)
      CLEAR: begin
        sample_we_o    = 1'b1;
        sample_wzero_o = 1'b1;
        sample_waddr_o = clr_cnt_q;
        clr_cnt_d      = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        in_ready_o = ~stall_i & ~abort_i;
        if (abort_i) begin
          tap_d = '0;
        end else if (in_valid_i && in_ready_o) begin
          sample_we_o    = 1'b1;
          sample_waddr_o = wptr_q;
          newest_d       = wptr_q;
          wptr_d         = wptr_q + 1'b1;
          tap_d          = '0;
          state_d        = MAC;
        end
      end
      MAC: begin
        issue_o        = 1'b1;
        coef_raddr_o   = tap_q;
        // Newest sample pairs with coef 0, older ones walk backwards.
        sample_raddr_o = newest_q - tap_q;
        overwrite_o    = (tap_q == '0);
        output_valid_o = (tap_q == LAST);
        if (abort_i) begin
          tap_d   = '0;
          state_d = IDLE;
        end else if (!stall_i) begin
          tap_d = tap_q + 1'b1;
          if (tap_q == LAST) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

endmodule

// File: tb/tb_fir_filter_ctrl.sv
// Directed self-checking bench for fir_filter_ctrl with NUM_TAPS = 4.
module tb_fir_filter_ctrl;

  localparam int N  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          stall;
  logic          abort;
  logic          we;
  logic          wzero;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic [AW-1:0] caddr;
  logic          issue;
  logic          ovw;
  logic          ovalid;
  logic          freeze;
  logic          flush;
  logic          busy;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fir_filter_ctrl #(.NUM_TAPS(N), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .stall_i        (stall),
    .abort_i        (abort),
    .sample_we_o    (we),
    .sample_wzero_o (wzero),
    .sample_waddr_o (waddr),
    .sample_raddr_o (raddr),
    .coef_raddr_o   (caddr),
    .issue_o        (issue),
    .overwrite_o    (ovw),
    .output_valid_o (ovalid),
    .freeze_o       (freeze),
    .flush_o        (flush),
    .busy_o         (busy)
  );

  // Bundle order: ready we wzero waddr issue raddr coef ovw ovalid freeze flush busy
  logic [14:0] obs;
  assign obs = {in_ready, we, wzero, waddr, issue, raddr, caddr,
                ovw, ovalid, freeze, flush, busy};

  function automatic logic [14:0] mk(
    input logic ir, input logic w, input logic wz, input logic [1:0] wa,
    input logic is, input logic [1:0] ra, input logic [1:0] ca,
    input logic ow, input logic ov, input logic fz, input logic fl,
    input logic by);
    return {ir, w, wz, wa, is, ra, ca, ow, ov, fz, fl, by};
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; abort = 1'b0;
    next();
    next();
    rst = 1'b0;
    for (int i = 0; i < N; i++) next();
  endtask

  task automatic test_reset();
    logic [14:0] e;
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; abort = 1'b0;
    next();
    #1;
    e = mk(0, 1, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (obs !== e) begin
      fails++;
      $display("FAIL reset_state got %h want %h", obs, e);
    end
    next();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      abort = (i == 1);
      stall = (i == 2);
      #1;
      e = mk(0, 1, 1, 2'(i), 0, 0, 0, 0, 0, stall, abort, 1);
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL reset_clear c%0d got %h want %h", i, obs, e);
      end
      next();
    end
    abort = 1'b0; stall = 1'b0;
    #1;
    e = mk(1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin
      fails++;
      $display("FAIL reset_ready got %h want %h", obs, e);
    end
    next();
  endtask

  task automatic test_single();
    logic [14:0] e;
    do_reset();
    in_valid = 1'b1;
    #1;
    e = mk(1, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin
      fails++;
      $display("FAIL single_accept got %h want %h", obs, e);
    end
    next();
    in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      #1;
      e = mk(0, 0, 0, 2'd0, 1, 2'(N - k), 2'(k), k == 0, k == N - 1,
             0, 0, 1);
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL single_tap%0d got %h want %h", k, obs, e);
      end
      next();
    end
    #1;
    e = mk(1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin
      fails++;
      $display("FAIL single_done got %h want %h", obs, e);
    end
    next();
  endtask

  task automatic test_stall();
    logic [14:0] e;
    do_reset();
    in_valid = 1'b1;
    #1;
    e = mk(1, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin
      fails++;
      $display("FAIL stall_accept got %h want %h", obs, e);
    end
    next();
    in_valid = 1'b0;
    #1;
    e = mk(0, 0, 0, 2'd0, 1, 2'd0, 2'd0, 1, 0, 0, 0, 1);
    checks++;
    if (obs !== e) begin
      fails++;
      $display("FAIL stall_tap0 got %h want %h", obs, e);
    end
    next();
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      e = mk(0, 0, 0, 2'd0, 1, 2'd3, 2'd1, 0, 0, 1, 0, 1);
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL stall_hold%0d got %h want %h", s, obs, e);
      end
      next();
    end
    stall = 1'b0;
    #1;
    e = mk(0, 0, 0, 2'd0, 1, 2'd3, 2'd1, 0, 0, 0, 0, 1);
    checks++;
    if (obs !== e) begin
      fails++;
      $display("FAIL stall_release got %h want %h", obs, e);
    end
    next();
    #1;
    e = mk(0, 0, 0, 2'd0, 1, 2'd2, 2'd2, 0, 0, 0, 0, 1);
    checks++;
    if (obs !== e) begin
      fails++;
      $display("FAIL stall_tap2 got %h want %h", obs, e);
    end
    next();
    #1;
    e = mk(0, 0, 0, 2'd0, 1, 2'd1, 2'd3, 0, 1, 0, 0, 1);
    checks++;
    if (obs !== e) begin
      fails++;
      $display("FAIL stall_tap3 got %h want %h", obs, e);
    end
    next();
    #1;
    e = mk(1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin
      fails++;
      $display("FAIL stall_done got %h want %h", obs, e);
    end
    next();
  endtask

  task automatic test_abort();
    logic [14:0] e;
    do_reset();
    in_valid = 1'b1;
    next();
    in_valid = 1'b0;
    next();
    next();
    abort = 1'b1;
    #1;
    e = mk(0, 0, 0, 2'd0, 1, 2'd2, 2'd2, 0, 0, 0, 1, 1);
    checks++;
    if (obs !== e) begin
      fails++;
      $display("FAIL abort_tap2 got %h want %h", obs, e);
    end
    next();
    abort = 1'b0;
    in_valid = 1'b1;
    #1;
    e = mk(1, 1, 0, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin
      fails++;
      $display("FAIL abort_reaccept got %h want %h", obs, e);
    end
    next();
    in_valid = 1'b0;
    #1;
    e = mk(0, 0, 0, 2'd0, 1, 2'd1, 2'd0, 1, 0, 0, 0, 1);
    checks++;
    if (obs !== e) begin
      fails++;
      $display("FAIL abort_newtap0 got %h want %h", obs, e);
    end
    for (int i = 0; i < N; i++) next();
  endtask

  task automatic test_back_to_back();
    logic [14:0] e;
    int t;
    int nw;
    do_reset();
    for (int c = 0; c < 5 * (N + 1); c++) begin
      in_valid = 1'b1;
      #1;
      if (c % 5 == 0) begin
        e = mk(1, 1, 0, 2'(c / 5), 0, 0, 0, 0, 0, 0, 0, 0);
      end else begin
        t  = c % 5 - 1;
        nw = (c / 5) % N;
        e = mk(0, 0, 0, 2'd0, 1, 2'(nw - t + N), 2'(t), t == 0,
               t == N - 1, 0, 0, 1);
      end
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL wrap_c%0d got %h want %h", c, obs, e);
      end
      next();
    end
    in_valid = 1'b0;
    #1;
    e = mk(1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin
      fails++;
      $display("FAIL wrap_done got %h want %h", obs, e);
    end
    next();
  endtask

  task automatic test_simultaneous();
    logic [14:0] e;
    do_reset();
    abort = 1'b1;
    in_valid = 1'b1;
    #1;
    e = mk(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (obs !== e) begin
      fails++;
      $display("FAIL simul_abort got %h want %h", obs, e);
    end
    next();
    abort = 1'b0;
    stall = 1'b1;
    for (int s = 0; s < 2; s++) begin
      #1;
      e = mk(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0);
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL simul_stall%0d got %h want %h", s, obs, e);
      end
      next();
    end
    stall = 1'b0;
    #1;
    e = mk(1, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin
      fails++;
      $display("FAIL simul_accept got %h want %h", obs, e);
    end
    next();
    in_valid = 1'b0;
    #1;
    e = mk(0, 0, 0, 2'd0, 1, 2'd0, 2'd0, 1, 0, 0, 0, 1);
    checks++;
    if (obs !== e) begin
      fails++;
      $display("FAIL simul_tap0 got %h want %h", obs, e);
    end
    for (int i = 0; i < N; i++) next();
  endtask

  task automatic test_rst_mac();
    logic [14:0] e;
    do_reset();
    in_valid = 1'b1;
    next();
    in_valid = 1'b0;
    next();
    rst = 1'b1;
    #1;
    e = mk(0, 0, 0, 2'd0, 1, 2'd3, 2'd1, 0, 0, 0, 0, 1);
    checks++;
    if (obs !== e) begin
      fails++;
      $display("FAIL rstmac_tap1 got %h want %h", obs, e);
    end
    next();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      #1;
      e = mk(0, 1, 1, 2'(i), 0, 0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (obs !== e) begin
        fails++;
        $display("FAIL rstmac_clear%0d got %h want %h", i, obs, e);
      end
      next();
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; abort = 1'b0;
    test_reset();
    test_single();
    test_stall();
    test_abort();
    test_back_to_back();
    test_simultaneous();
    test_rst_mac();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/fir_filter_ctrl.md
# fir_filter_ctrl

Sequencer for the multi-stage FIR filter datapath. It accepts input samples over a valid/ready handshake, writes each sample into a circular sample buffer, and steps the read/multiply/accumulate pipeline through all taps. Per tap it drives the sample and coefficient read addresses and the `overwrite`/`output_valid` flags that travel down the pipeline registers. It also generates the pipeline-wide `freeze` and `flush` controls, and zero-fills the sample buffer after reset.

## Interface
- `NUM_TAPS`, 16: number of filter taps; must be ≥ 2.
- `ADDR_WIDTH`, 4: buffer address width; `2**ADDR_WIDTH == NUM_TAPS`.

- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  new input sample available.
- `in_ready`  out  1  controller accepts a sample this cycle.
- `stall`  in  1  downstream backpressure; holds the sequence.
- `abort`  in  1  cancel the current sample's computation.
- `sample_we`  out  1  sample buffer write enable.
- `sample_wzero`  out  1  write zero instead of the input sample (clear phase).
- `sample_waddr`  out  ADDR_WIDTH  sample buffer write address.
- `sample_raddr`  out  ADDR_WIDTH  sample buffer read address for the current tap.
- `coef_raddr`  out  ADDR_WIDTH  coefficient ROM/RAM read address for the current tap.
- `issue`  out  1  tap addresses are valid this cycle.
- `overwrite`  out  1  first tap: the accumulator loads instead of adding.
- `output_valid`  out  1  last tap: the accumulator result is final.
- `freeze`  out  1  pipeline register freeze.
- `flush`  out  1  pipeline register flush.
- `busy`  out  1  state is not IDLE.

## Operation
- **Registers:**
  - state ∈ {CLEAR, IDLE, MAC}.
  - `wptr` (ADDR_WIDTH).
  - `newest` (ADDR_WIDTH).
  - `tap` (ADDR_WIDTH).
  - `clr_cnt` (ADDR_WIDTH).
- **Outputs:** all outputs are combinational from registers and inputs.
- **Reset** (`rst` high at a clock edge), next state:
  - state = CLEAR.
  - `wptr`, `newest`, `tap`, `clr_cnt` = 0.
- **CLEAR:**
  - Drives `sample_we` = 1, `sample_wzero` = 1, `sample_waddr` = `clr_cnt`.
  - `clr_cnt` increments each cycle. After the write of address `NUM_TAPS-1`, the next state is IDLE.
  - `stall` and `abort` do not affect the clear sequence. `abort` still drives `flush` = 1.
- **IDLE:**
  - `in_ready` = ~`stall` & ~`abort`.
  - On acceptance (`in_valid` & `in_ready`):
    - Drives `sample_we` = 1, `sample_wzero` = 0, `sample_waddr` = `wptr`.
    - Next: `newest` = `wptr`, `wptr` = `wptr`+1 (mod `NUM_TAPS`), `tap` = 0, state = MAC.
- **MAC:**
  - Drives `issue` = 1 and `coef_raddr` = `tap`.
  - Drives `sample_raddr` = (`newest` − `tap`) mod `NUM_TAPS`.
  - `overwrite` = (`tap` == 0).
  - `output_valid` = (`tap` == `NUM_TAPS`−1).
  - If `stall` = 0, `tap` increments. After the last tap, the next state is IDLE.
  - If `stall` = 1, `tap` and all MAC outputs hold their values.
- **Freeze and flush:**
  - `freeze` = `stall` in every state.
  - `flush` = `abort` in every state.
- **Abort in MAC or IDLE:**
  - Next state is IDLE and `tap` = 0.
  - `wptr` and `newest` are retained, so the aborted sample stays in the buffer.
  - `abort` has priority over `stall` and over `in_valid`.
- **Outputs not listed for a state** are 0.
- **`busy`** = (state ≠ IDLE).
- **Modular arithmetic:** all address arithmetic wraps mod `NUM_TAPS`; no width extension.

## Timing
- **After `rst` deasserts:**
  - `NUM_TAPS` cycles of CLEAR.
  - `in_ready` can first be 1 at cycle `NUM_TAPS` (counting from 0).
- **Accept at cycle T:**
  - Write at T.
  - Taps 0..`NUM_TAPS`−1 are issued at T+1..T+`NUM_TAPS`.
  - `in_ready` is high again at T+`NUM_TAPS`+1.
- **Throughput:** one sample per `NUM_TAPS`+1 cycles with no stalls.
- **Stall:** each stalled cycle in MAC adds exactly one cycle of latency.
- **Buffer reuse:** the slot overwritten by the next sample equals the last tap's read address. That read always completes before the next write, so no read/write collision occurs.
- **`rst` during MAC:** the sequence is lost, no `output_valid` is produced, and CLEAR restarts.

## Test plan
All scenarios use `NUM_TAPS` = 4.
- **Reset clear:** `rst` high 2 cycles, then low → 4 cycles with `sample_we` = `sample_wzero` = 1 and `waddr` 0, 1, 2, 3 while `in_ready` = 0; `in_ready` = 1 on the 5th cycle.
- **Single sample:** `wptr` = 0 and `in_valid` at T → write to addr 0 at T.
  - T+1..T+4 drive `raddr` 0, 3, 2, 1 and `coef` 0, 1, 2, 3.
  - `overwrite` is high only at T+1; `output_valid` is high only at T+4.
  - `busy` drops and `in_ready` = 1 at T+5.
- **Stall:** `stall` high 3 cycles while at tap 1 → `raddr` 3 / `coef` 1 held for 4 cycles with `freeze` = 1 for 3 of them; `output_valid` at T+7; no tap is skipped or repeated after release.
- **Abort mid-MAC:** `abort` at tap 2 → `flush` = 1 for exactly that cycle; next cycle is IDLE with `in_ready` = 1; `wptr` stays at 1, so the next sample writes addr 1.
- **Wrap-around:** 5 back-to-back samples with `in_valid` held high → writes to addr 0, 1, 2, 3, 0 spaced 5 cycles apart; the 5th sample reads `raddr` 0, 3, 2, 1.
- **Simultaneous events in IDLE:** `abort` and `in_valid` together → no write, `in_ready` = 0, `flush` = 1. `stall` and `in_valid` together → no accept until `stall` drops.
